// File: rtl/sb_gb_sync.sv
// rtl/sb_gb_sync.sv - N-stage 1-bit synchronizer with synchronous active-high reset
module sb_gb_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/sb_gb.sv
// rtl/sb_gb.sv - global buffer pass-through with a clk-domain edge/stuck activity monitor
module sb_gb #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             USER_SIGNAL_TO_GLOBAL_BUFFER,
    output logic             GLOBAL_BUFFER_OUTPUT,
    input  logic             mon_clr,
    output logic             mon_level,
    output logic [CNT_W-1:0] mon_rise_cnt,
    output logic [CNT_W-1:0] mon_fall_cnt,
    output logic             mon_active,
    output logic             mon_stuck
);

    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int PW        = $clog2(PRIME_MAX + 1);
    localparam int IW        = $clog2(TIMEOUT + 1);

    localparam logic [PW-1:0]    PRIME_DONE = PW'(PRIME_MAX);
    localparam logic [IW-1:0]    IDLE_MAX   = IW'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    // The buffered net never touches a flop: monitor logic only observes it.
    assign GLOBAL_BUFFER_OUTPUT = USER_SIGNAL_TO_GLOBAL_BUFFER;

    logic             w_level;
    logic             w_primed;
    logic             w_rise;
    logic             w_fall;
    logic             w_edge;
    logic             r_prev;
    logic [PW-1:0]    r_prime;
    logic [IW-1:0]    r_idle;
    logic [CNT_W-1:0] r_rise_cnt;
    logic [CNT_W-1:0] r_fall_cnt;
    logic             r_seen;

    sb_gb_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (USER_SIGNAL_TO_GLOBAL_BUFFER),
        .q   (w_level)
    );

    // Edges are ignored until the synchronizer and prev flop hold real samples.
    assign w_primed = (r_prime == PRIME_DONE);
    assign w_rise   = w_primed & w_level & ~r_prev;
    assign w_fall   = w_primed & ~w_level & r_prev;
    assign w_edge   = w_rise | w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev     <= 1'b0;
            r_prime    <= '0;
            r_idle     <= '0;
            r_rise_cnt <= '0;
            r_fall_cnt <= '0;
            r_seen     <= 1'b0;
        end else begin
            r_prev <= w_level;
            if (r_prime != PRIME_DONE) begin
                r_prime <= r_prime + PW'(1);
            end
            if (mon_clr) begin
                r_idle     <= '0;
                r_rise_cnt <= '0;
                r_fall_cnt <= '0;
                r_seen     <= 1'b0;
            end else begin
                if (w_rise && (r_rise_cnt != CNT_MAX)) begin
                    r_rise_cnt <= r_rise_cnt + CNT_W'(1);
                end
                if (w_fall && (r_fall_cnt != CNT_MAX)) begin
                    r_fall_cnt <= r_fall_cnt + CNT_W'(1);
                end
                if (w_edge) begin
                    r_idle <= '0;
                    r_seen <= 1'b1;
                end else if (r_idle != IDLE_MAX) begin
                    r_idle <= r_idle + IW'(1);
                end
            end
        end
    end

    assign mon_level    = w_level;
    assign mon_rise_cnt = r_rise_cnt;
    assign mon_fall_cnt = r_fall_cnt;
    assign mon_stuck    = (r_idle == IDLE_MAX);
    assign mon_active   = r_seen & ~mon_stuck;

endmodule

// File: tb/tb_sb_gb.sv
// tb/tb_sb_gb.sv - self-checking bench for sb_gb against a sampled-history reference model
module tb_sb_gb;

    localparam int CW  = 4;
    localparam int TO  = 8;
    localparam int S   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk;
    logic          clk_run;
    logic          rst;
    logic          sig;
    logic          gbo;
    logic          mon_clr;
    logic          mon_level;
    logic [CW-1:0] mon_rise_cnt;
    logic [CW-1:0] mon_fall_cnt;
    logic          mon_active;
    logic          mon_stuck;

    int n_tests = 0;
    int n_fail  = 0;

    sb_gb #(
        .CNT_W       (CW),
        .TIMEOUT     (TO),
        .SYNC_STAGES (S)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .USER_SIGNAL_TO_GLOBAL_BUFFER (sig),
        .GLOBAL_BUFFER_OUTPUT         (gbo),
        .mon_clr                      (mon_clr),
        .mon_level                    (mon_level),
        .mon_rise_cnt                 (mon_rise_cnt),
        .mon_fall_cnt                 (mon_fall_cnt),
        .mon_active                   (mon_active),
        .mon_stuck                    (mon_stuck)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Reference model: h[c] is the input captured at the c-th edge since reset
    // (h[0] = 0 for the reset edge). A change captured at edge k is counted at
    // edge k+S, once S+1 post-reset edges have passed.
    int m_h[$];
    int m_c;
    int m_rise, m_fall, m_idle, m_seen, m_level;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int  lv_idx;
        bit  ev;
        if (rst) begin
            m_h.delete();
            m_h.push_back(0);
            m_c    = 0;
            m_rise = 0;
            m_fall = 0;
            m_idle = 0;
            m_seen = 0;
            m_valid = 1'b1;
        end else begin
            m_c = m_c + 1;
            m_h.push_back(int'(sig));
            ev = (m_c >= S + 2) && (m_h[m_c-S] != m_h[m_c-S-1]);
            if (mon_clr) begin
                m_rise = 0;
                m_fall = 0;
                m_idle = 0;
                m_seen = 0;
            end else if (ev) begin
                if (m_h[m_c-S] == 1) begin
                    if (m_rise < MAXC) m_rise = m_rise + 1;
                end else begin
                    if (m_fall < MAXC) m_fall = m_fall + 1;
                end
                m_idle = 0;
                m_seen = 1;
            end else if (m_idle < TO) begin
                m_idle = m_idle + 1;
            end
        end
        lv_idx  = m_c - S + 1;
        m_level = (lv_idx >= 1) ? m_h[lv_idx] : 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int st;
        @(negedge clk);
        if (m_valid) begin
            st = (m_idle == TO) ? 1 : 0;
            chk("mdl_level",  32'(mon_level),    32'(m_level));
            chk("mdl_rise",   32'(mon_rise_cnt), 32'(m_rise));
            chk("mdl_fall",   32'(mon_fall_cnt), 32'(m_fall));
            chk("mdl_stuck",  32'(mon_stuck),    32'(st));
            chk("mdl_active", 32'(mon_active),   32'((m_seen == 1) && (st == 0)));
        end
        chk("mdl_gbuf", 32'(gbo), 32'(sig));
    endtask

    task automatic pulse(input int hi, input int lo);
        sig = 1'b1;
        repeat (hi) tick();
        sig = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        int mode;
        clk_run = 1'b0;
        rst     = 1'b1;
        mon_clr = 1'b0;
        sig     = 1'b0;

        // Pass-through with clk stopped and rst held
        for (int i = 0; i < 12; i++) begin
            sig = 1'($urandom_range(0, 1));
            #1;
            chk("pass_through", 32'(gbo), 32'(sig));
            #($urandom_range(1, 7));
        end

        sig = 1'b0;
        clk_run = 1'b1;
        repeat (3) tick();
        chk("reset_rise",   32'(mon_rise_cnt), 32'd0);
        chk("reset_fall",   32'(mon_fall_cnt), 32'd0);
        chk("reset_active", 32'(mon_active),   32'd0);
        chk("reset_stuck",  32'(mon_stuck),    32'd0);
        chk("reset_level",  32'(mon_level),    32'd0);
        rst = 1'b0;
        repeat (6) tick();

        // Single pulse: rise count lands exactly S edges after capture
        sig = 1'b1;
        repeat (S) tick();
        chk("pulse_rise_early", 32'(mon_rise_cnt), 32'd0);
        tick();
        chk("pulse_rise_on_time", 32'(mon_rise_cnt), 32'd1);
        chk("pulse_active", 32'(mon_active), 32'd1);
        repeat (7) tick();
        sig = 1'b0;
        repeat (3) tick();
        chk("pulse_fall", 32'(mon_fall_cnt), 32'd1);

        // Stuck: fall update was on the last tick; TIMEOUT more edges to assert
        repeat (TO - 1) tick();
        chk("stuck_early", 32'(mon_stuck), 32'd0);
        tick();
        chk("stuck_on_time", 32'(mon_stuck),  32'd1);
        chk("stuck_active",  32'(mon_active), 32'd0);
        sig = 1'b1;
        repeat (3) tick();
        chk("stuck_cleared", 32'(mon_stuck),    32'd0);
        chk("stuck_reactive", 32'(mon_active),  32'd1);
        chk("stuck_rise2",   32'(mon_rise_cnt), 32'd2);
        sig = 1'b0;
        repeat (4) tick();

        // Clear with counts at 5
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        repeat (5) pulse(3, 3);
        chk("clr_pre_rise", 32'(mon_rise_cnt), 32'd5);
        chk("clr_pre_fall", 32'(mon_fall_cnt), 32'd5);
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        chk("clr_rise",   32'(mon_rise_cnt), 32'd0);
        chk("clr_fall",   32'(mon_fall_cnt), 32'd0);
        chk("clr_active", 32'(mon_active),   32'd0);
        chk("clr_stuck",  32'(mon_stuck),    32'd0);

        // Edge coinciding with clear is discarded
        sig = 1'b1;
        repeat (S) tick();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        chk("coincide_rise", 32'(mon_rise_cnt), 32'd0);
        repeat (3) tick();
        chk("coincide_rise_later", 32'(mon_rise_cnt), 32'd0);
        chk("coincide_active",     32'(mon_active),   32'd0);

        // rst and mon_clr together, then static high held through release
        mon_clr = 1'b1;
        rst     = 1'b1;
        tick();
        chk("rstclr_level",  32'(mon_level),    32'd0);
        chk("rstclr_rise",   32'(mon_rise_cnt), 32'd0);
        chk("rstclr_active", 32'(mon_active),   32'd0);
        rst     = 1'b0;
        mon_clr = 1'b0;
        repeat (TO + 4) tick();
        chk("static_high_rise",   32'(mon_rise_cnt), 32'd0);
        chk("static_high_fall",   32'(mon_fall_cnt), 32'd0);
        chk("static_high_active", 32'(mon_active),   32'd0);
        chk("static_high_level",  32'(mon_level),    32'd1);

        // Saturation after 20 pulses
        sig = 1'b0;
        repeat (4) tick();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        repeat (20) pulse(2, 2);
        repeat (3) tick();
        chk("sat_rise", 32'(mon_rise_cnt), 32'(MAXC));
        chk("sat_fall", 32'(mon_fall_cnt), 32'(MAXC));

        // Randomized traffic: fast (aliasing), slow and quiet phases with clears
        for (int blk = 0; blk < 10; blk++) begin
            mode = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            for (int i = 0; i < 40; i++) begin
                if (mode == 0) sig = 1'($urandom_range(0, 1));
                else if (mode == 1 && $urandom_range(0, 5) == 0) sig = ~sig;
                mon_clr = ($urandom_range(0, 39) == 0);
                tick();
            end
            mon_clr = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
